// File: rtl/uart_apb_pkg.sv
// ============================================================================
// Module   : uart_apb_pkg
// Brief    : CoreUARTapb register map, STATUS bit indices and scheduler FSM states
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_apb_pkg;

  localparam logic [4:0] c_ADDR_TXDATA = 5'h00;
  localparam logic [4:0] c_ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] c_ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] c_ADDR_STATUS = 5'h10;

  localparam int c_STATUS_TXRDY = 0;

  typedef enum logic [2:0] {
    INIT1  = 3'd0,
    INIT2  = 3'd1,
    IDLE   = 3'd2,
    POLL_S = 3'd3,
    POLL_A = 3'd4,
    WR_S   = 3'd5,
    WR_A   = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_apb_tx_sched_if.sv
// ============================================================================
// Module   : uart_apb_tx_sched_if
// Brief    : Requester handshake plus APB master bundle of the TX scheduler
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_apb_tx_sched_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [4:0]        PADDR;
  logic [7:0]        PWDATA;
  logic [7:0]        PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_data, PRDATA, PREADY, PSLVERR,
    output req_ready, grant_id, busy, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_data, PRDATA, PREADY, PSLVERR,
    input  req_ready, grant_id, busy, err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
// ============================================================================
// Module   : uart_rr_arbiter
// Brief    : Combinational round-robin arbiter; search starts one past i_last
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  wire logic [NREQ-1:0] i_req,
  input  wire logic [IDW-1:0]  i_last,
  output logic      [NREQ-1:0] o_grant,
  output logic      [IDW-1:0]  o_idx,
  output logic                 o_any
);

  always_comb begin : p_search
    int             w_pos;
    logic [IDW-1:0] w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    // Offset NREQ wraps back to i_last itself, so it has lowest priority.
    for (int off = 1; off <= NREQ; off++) begin
      w_pos = int'(i_last) + off;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_cand = IDW'(w_pos);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_apb_tx_sched.sv
// ============================================================================
// Module   : uart_apb_tx_sched
// Brief    : Round-robin TX byte scheduler acting as APB master of CoreUARTapb.
//            Define UART_TX_SCHED_INIT_EN to program CTRL1/CTRL2 after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_apb_tx_sched
  import uart_apb_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter logic [2:0]  MODE_BITS  = 3'b001
) (
  input  wire logic           PCLK,
  input  wire logic           PRESETN,
  uart_apb_tx_sched_if.master bus
);

  localparam int             IDW        = $clog2(NREQ);
  localparam logic [IDW-1:0] c_LAST_RST = IDW'(NREQ - 1);

`ifdef UART_TX_SCHED_INIT_EN
  localparam state_t     c_ENTRY     = INIT1;
  localparam logic [7:0] c_CTRL1_VAL = BAUD_VALUE[7:0];
  localparam logic [7:0] c_CTRL2_VAL = {BAUD_VALUE[12:8], MODE_BITS};
`else
  localparam state_t     c_ENTRY     = IDLE;
`endif

  state_t         r_state;
  logic           r_psel;
  logic           r_penable;
  logic           r_pwrite;
  logic [4:0]     r_paddr;
  logic [7:0]     r_pwdata;
  logic [7:0]     r_byte;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] r_grant;
  logic           r_busy;
  logic           r_err;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_any;
  logic            w_done;
  logic            w_txrdy;
  logic            w_unused;

  uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_done   = r_psel & r_penable & bus.PREADY;
  // A slave error on a poll reads as "not ready" so the byte is never lost.
  assign w_txrdy  = bus.PRDATA[c_STATUS_TXRDY] & ~bus.PSLVERR;
  assign w_unused = &{1'b0, bus.PRDATA[7:1]};

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state   <= c_ENTRY;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_byte    <= '0;
      r_last    <= c_LAST_RST;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_done && bus.PSLVERR) r_err <= 1'b1;

      case (r_state)
`ifdef UART_TX_SCHED_INIT_EN
        INIT1: begin
          r_busy <= 1'b1;
          if (!r_psel) begin
            r_psel   <= 1'b1;
            r_pwrite <= 1'b1;
            r_paddr  <= c_ADDR_CTRL1;
            r_pwdata <= c_CTRL1_VAL;
          end else if (!r_penable) begin
            r_penable <= 1'b1;
          end else if (bus.PREADY) begin
            r_penable <= 1'b0;
            r_paddr   <= c_ADDR_CTRL2;
            r_pwdata  <= c_CTRL2_VAL;
            r_state   <= INIT2;
          end
        end
        INIT2: begin
          if (!r_penable) begin
            r_penable <= 1'b1;
          end else if (bus.PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
`endif
        IDLE: begin
          if (w_any) begin
            r_byte    <= bus.req_data[w_idx*8 +: 8];
            r_grant   <= w_idx;
            r_last    <= w_idx;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= c_ADDR_STATUS;
            r_busy    <= 1'b1;
            r_state   <= POLL_S;
          end
        end
        POLL_S: begin
          r_penable <= 1'b1;
          r_state   <= POLL_A;
        end
        POLL_A: begin
          if (bus.PREADY) begin
            r_penable <= 1'b0;
            if (w_txrdy) begin
              r_pwrite <= 1'b1;
              r_paddr  <= c_ADDR_TXDATA;
              r_pwdata <= r_byte;
              r_state  <= WR_S;
            end else begin
              r_state  <= POLL_S;
            end
          end
        end
        WR_S: begin
          r_penable <= 1'b1;
          r_state   <= WR_A;
        end
        WR_A: begin
          if (bus.PREADY) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_pwrite  <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= c_ENTRY;
        end
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE) ? w_grant : '0;
  assign bus.grant_id  = r_grant;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_tx_sched.sv
// ============================================================================
// Module   : tb_uart_apb_tx_sched
// Brief    : Directed self-checking bench for uart_apb_tx_sched with an APB slave model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_apb_tx_sched;

  typedef struct {
    logic [4:0] addr;
    logic       wr;
    logic [7:0] data;
    logic       slverr;
  } xfer_t;

  logic PCLK    = 1'b0;
  logic PRESETN = 1'b0;
  always #5 PCLK = ~PCLK;

  uart_apb_tx_sched_if #(.NREQ(4)) bus ();

  uart_apb_tx_sched #(
    .NREQ       (4),
    .BAUD_VALUE (13'h145),
    .MODE_BITS  (3'b011)
  ) dut (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave configuration, written only by the test tasks.
  int wr_stall_cfg = 0;
  bit wr_err_cfg   = 1'b0;
  int stat_zeros   = 0;
  int stat_base    = 0;

  // Written only by the monitors.
  xfer_t xq[$];
  int    acc_q[$];
  int    rd_count   = 0;
  int    nonhot_cnt = 0;
  int    st_cnt     = 0;

  always @(negedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) begin
      if (bus.PWRITE && bus.PADDR == 5'h00 && st_cnt < wr_stall_cfg) begin
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        st_cnt++;
      end else begin
        bus.PREADY = 1'b1;
        if (!bus.PWRITE) begin
          bus.PRDATA  = ((rd_count - stat_base) < stat_zeros) ? 8'h00 : 8'h01;
          bus.PSLVERR = 1'b0;
        end else begin
          bus.PSLVERR = (bus.PADDR == 5'h00) && wr_err_cfg;
        end
      end
    end else begin
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
      bus.PRDATA  = 8'h00;
      st_cnt      = 0;
    end
    if (bus.req_ready != 4'b0000 && !$onehot(bus.req_ready)) nonhot_cnt++;
  end

  always @(posedge PCLK) begin
    if (PRESETN) begin
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        xfer_t x;
        x.addr   = bus.PADDR;
        x.wr     = bus.PWRITE;
        x.data   = bus.PWRITE ? bus.PWDATA : bus.PRDATA;
        x.slverr = bus.PSLVERR;
        xq.push_back(x);
        if (!bus.PWRITE && bus.PADDR == 5'h10) rd_count++;
      end
      for (int i = 0; i < 4; i++) if (bus.req_ready[i]) acc_q.push_back(i);
    end
  end

  // Offers one byte, waits for its accept, then counts edges until busy drops.
  task automatic send_byte(input int k, input logic [7:0] d, output int n, output bit ok);
    bit acc;
    acc = 1'b0;
    ok  = 1'b0;
    n   = 0;
    @(negedge PCLK);
    bus.req_valid[k]       = 1'b1;
    bus.req_data[k*8 +: 8] = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      if (bus.req_ready[k]) acc = 1'b1;
      else @(negedge PCLK);
    end
    if (!acc) begin
      bus.req_valid[k] = 1'b0;
      return;
    end
    @(posedge PCLK);
    #1;
    bus.req_valid[k] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge PCLK);
      #1;
      n++;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESETN = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    repeat (8) @(negedge PCLK);
  endtask

  task automatic test_reset();
    logic bz [1:5];
    int   x0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin
      errors++; $display("FAIL reset_apb_ctl got %b exp 000", {bus.PSEL, bus.PENABLE, bus.PWRITE});
    end
    checks++;
    if ({bus.PADDR, bus.PWDATA} !== 13'h0000) begin
      errors++; $display("FAIL reset_apb_data got %h exp 0000", {bus.PADDR, bus.PWDATA});
    end
    checks++;
    if ({bus.busy, bus.err, bus.grant_id, bus.req_ready} !== 8'h00) begin
      errors++; $display("FAIL reset_status got %h exp 00", {bus.busy, bus.err, bus.grant_id, bus.req_ready});
    end
    x0 = xq.size();
    PRESETN = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge PCLK);
      #1;
      bz[e] = bus.busy;
    end
`ifdef UART_TX_SCHED_INIT_EN
    checks++;
    if ({bz[1], bz[2], bz[3], bz[4], bz[5]} !== 5'b11110) begin
      errors++; $display("FAIL init_busy got %b exp 11110", {bz[1], bz[2], bz[3], bz[4], bz[5]});
    end
    checks++;
    if (xq.size() - x0 != 2) begin
      errors++; $display("FAIL init_count got %0d exp 2", xq.size() - x0);
    end else begin
      checks++;
      if ({xq[x0].addr, xq[x0].wr, xq[x0].data} !== {5'h08, 1'b1, 8'h45}) begin
        errors++; $display("FAIL init_ctrl1 got a=%h d=%h exp a=08 d=45", xq[x0].addr, xq[x0].data);
      end
      checks++;
      if ({xq[x0+1].addr, xq[x0+1].wr, xq[x0+1].data} !== {5'h0C, 1'b1, 8'h0B}) begin
        errors++; $display("FAIL init_ctrl2 got a=%h d=%h exp a=0C d=0B", xq[x0+1].addr, xq[x0+1].data);
      end
    end
`else
    checks++;
    if ({bz[1], bz[2], bz[3], bz[4], bz[5]} !== 5'b00000) begin
      errors++; $display("FAIL noinit_busy got %b exp 00000", {bz[1], bz[2], bz[3], bz[4], bz[5]});
    end
    checks++;
    if (xq.size() != x0) begin
      errors++; $display("FAIL noinit_xfers got %0d exp 0", xq.size() - x0);
    end
`endif
  endtask

  task automatic test_single();
    int n, x0, a0;
    bit ok;
    x0 = xq.size();
    a0 = acc_q.size();
    send_byte(2, 8'hA5, n, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_timeout got ok=%0b exp 1", ok);
    end
    // After the accept edge: POLL_S, POLL_A, WR_S, WR_A, then IDLE on the 4th edge.
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL single_latency got %0d exp 4", n);
    end
    checks++;
    if (acc_q.size() - a0 != 1 || acc_q[a0] != 2) begin
      errors++; $display("FAIL single_pulse got cnt=%0d exp cnt=1 idx=2", acc_q.size() - a0);
    end
    checks++;
    if (bus.grant_id !== 2'd2) begin
      errors++; $display("FAIL single_grant got %0d exp 2", bus.grant_id);
    end
    checks++;
    if (xq.size() - x0 != 2) begin
      errors++; $display("FAIL single_xfers got %0d exp 2", xq.size() - x0);
    end else begin
      checks++;
      if ({xq[x0].addr, xq[x0].wr, xq[x0+1].addr, xq[x0+1].wr, xq[x0+1].data} !== {5'h10, 1'b0, 5'h00, 1'b1, 8'hA5}) begin
        errors++; $display("FAIL single_seq got %h/%b then %h/%b/%h exp 10/0 then 00/1/a5",
                           xq[x0].addr, xq[x0].wr, xq[x0+1].addr, xq[x0+1].wr, xq[x0+1].data);
      end
    end
  endtask

  task automatic test_round_robin();
    int    x0, a0;
    bit    done;
    logic [7:0] wd[$];
    do_reset();
    x0 = xq.size();
    a0 = acc_q.size();
    done = 1'b0;
    @(negedge PCLK);
    bus.req_data  = 32'hC3C2C1C0;
    bus.req_valid = 4'hF;
    for (int i = 0; i < 200; i++) begin
      @(posedge PCLK);
      #1;
      if (acc_q.size() - a0 >= 8) begin
        done = 1'b1;
        break;
      end
    end
    bus.req_valid = 4'h0;
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge PCLK);
    checks++;
    if (!done) begin
      errors++; $display("FAIL rr_timeout got %0d accepts exp 8", acc_q.size() - a0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (acc_q[a0+i] != i % 4) begin
          errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, acc_q[a0+i], i % 4);
        end
      end
    end
    for (int i = x0; i < xq.size(); i++)
      if (xq[i].wr && xq[i].addr == 5'h00) wd.push_back(xq[i].data);
    checks++;
    if (wd.size() != 8) begin
      errors++; $display("FAIL rr_writes got %0d exp 8", wd.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wd[i] !== 8'(8'hC0 + i % 4)) begin
          errors++; $display("FAIL rr_data[%0d] got %h exp %h", i, wd[i], 8'(8'hC0 + i % 4));
        end
      end
    end
    checks++;
    if (nonhot_cnt != 0) begin
      errors++; $display("FAIL rr_onehot got %0d bad cycles exp 0", nonhot_cnt);
    end
  endtask

  task automatic test_txrdy_wait();
    int n, x0, rd, wr;
    bit ok;
    x0 = xq.size();
    stat_base  = rd_count;
    stat_zeros = 3;
    send_byte(1, 8'h3C, n, ok);
    stat_zeros = 0;
    rd = 0;
    wr = 0;
    for (int i = x0; i < xq.size(); i++) begin
      if (!xq[i].wr && xq[i].addr == 5'h10) rd++;
      if (xq[i].wr && xq[i].addr == 5'h00 && xq[i].data == 8'h3C) wr++;
    end
    checks++;
    if (!ok || n != 10) begin
      errors++; $display("FAIL txrdy_latency got %0d ok=%0b exp 10", n, ok);
    end
    checks++;
    if (rd != 4 || wr != 1) begin
      errors++; $display("FAIL txrdy_xfers got polls=%0d writes=%0d exp polls=4 writes=1", rd, wr);
    end
  endtask

  task automatic test_wait_states();
    bit seen;
    seen = 1'b0;
    wr_stall_cfg = 2;
    @(negedge PCLK);
    bus.req_valid[0] = 1'b1;
    bus.req_data[7:0] = 8'h5A;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge PCLK);
      if (!bus.busy) continue;
      bus.req_valid[0] = 1'b0;
      if (bus.PSEL && bus.PENABLE && bus.PWRITE) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL stall_reach got 0 exp 1");
    end else begin
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA} !== {1'b1, 1'b1, 5'h00, 8'h5A}) begin
          errors++; $display("FAIL stall_hold[%0d] got sel=%b en=%b a=%h d=%h exp 1 1 00 5a",
                             c, bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA);
        end
        @(negedge PCLK);
      end
      checks++;
      if ({bus.PSEL, bus.busy} !== 2'b00) begin
        errors++; $display("FAIL stall_done got sel=%b busy=%b exp 0 0", bus.PSEL, bus.busy);
      end
    end
    bus.req_valid[0] = 1'b0;
    wr_stall_cfg = 0;
  endtask

  task automatic test_pslverr_reset();
    int n, x0;
    bit ok, seen;
    wr_err_cfg = 1'b1;
    send_byte(3, 8'h77, n, ok);
    wr_err_cfg = 1'b0;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL err_set got %b exp 1", bus.err);
    end
    x0 = xq.size();
    send_byte(0, 8'h11, n, ok);
    checks++;
    if (!ok || bus.err !== 1'b1 || xq.size() - x0 != 2 || xq[xq.size()-1].data !== 8'h11) begin
      errors++; $display("FAIL err_next got ok=%0b err=%b exp ok=1 err=1 write 11", ok, bus.err);
    end
    // Abort mid-poll: latched 0x42 must never reach TXDATA.
    seen = 1'b0;
    @(negedge PCLK);
    bus.req_valid[1] = 1'b1;
    bus.req_data[15:8] = 8'h42;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge PCLK);
      if (bus.busy) bus.req_valid[1] = 1'b0;
      if (bus.PSEL && bus.PENABLE && !bus.PWRITE) seen = 1'b1;
    end
    bus.req_valid[1] = 1'b0;
    #2;
    PRESETN = 1'b0;
    #1;
    checks++;
    if ({seen, bus.PSEL, bus.PENABLE, bus.busy, bus.err} !== 5'b10000) begin
      errors++; $display("FAIL abort_async got seen=%b sel=%b en=%b busy=%b err=%b exp 1 0 0 0 0",
                         seen, bus.PSEL, bus.PENABLE, bus.busy, bus.err);
    end
    @(negedge PCLK);
    x0 = xq.size();
    PRESETN = 1'b1;
    repeat (6) @(negedge PCLK);
`ifdef UART_TX_SCHED_INIT_EN
    checks++;
    if (xq.size() - x0 != 2 || xq[x0].addr !== 5'h08) begin
      errors++; $display("FAIL abort_restart got %0d xfers exp 2 starting at 08", xq.size() - x0);
    end
`else
    checks++;
    if (xq.size() != x0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL abort_restart got %0d xfers busy=%b exp 0 0", xq.size() - x0, bus.busy);
    end
`endif
    x0 = xq.size();
    send_byte(2, 8'h99, n, ok);
    checks++;
    if (!ok || xq.size() - x0 != 2 || xq[xq.size()-1].data !== 8'h99 || bus.grant_id !== 2'd2) begin
      errors++; $display("FAIL abort_next got ok=%0b grant=%0d exp ok=1 grant=2 write 99", ok, bus.grant_id);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_txrdy_wait();
    test_wait_states();
    test_pslverr_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
